// File: rtl/qcs_rst_seq_pkg.sv
// Shared types and sizing helpers for the reset-sequencer receive block.
package qcs_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

    localparam int NUM_DOM_MIN   = 1;
    localparam int NUM_DOM_MAX   = 16;
    localparam int HOLD_CYC_MIN  = 1;
    localparam int STAGE_GAP_MIN = 1;

    // Wide enough to reach the longer of the two phase lengths without wrapping.
    function automatic int timer_w(input int hold_cyc, input int stage_gap);
        int longest;
        longest = (hold_cyc > stage_gap) ? hold_cyc : stage_gap;
        return $clog2(longest + 1);
    endfunction

    function automatic int idx_w(input int num_dom);
        return (num_dom <= 1) ? 1 : $clog2(num_dom);
    endfunction

    function automatic bit params_legal(input int num_dom, input int hold_cyc,
                                        input int stage_gap, input int cnt_w);
        return (num_dom >= NUM_DOM_MIN) && (num_dom <= NUM_DOM_MAX) &&
               (hold_cyc >= HOLD_CYC_MIN) && (stage_gap >= STAGE_GAP_MIN) &&
               (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/qcs_rst_seq_timer.sv
// Clearable up-counter with terminal-count compare, shared by HOLD and RELEASE.
module qcs_rst_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Count up each edge; a clear takes precedence over counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_r + W'(1);
        end
    end

    assign count = count_r;
    assign tc    = (count_r == term);

endmodule

// File: rtl/qcs_rst_seq_rx.sv
// Receive end of the reset generator: sequenced domain release plus a
// software reset request/acknowledge that replays the whole sequence.
module qcs_rst_seq_rx
    import qcs_rst_seq_pkg::*;
#(
    parameter int NUM_DOM   = 4,
    parameter int HOLD_CYC  = 8,
    parameter int STAGE_GAP = 4,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_rst_req,
    output logic               sw_rst_ack,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               seq_done,
    output logic [CNT_W-1:0]   rst_cnt
);

    localparam int TW = timer_w(HOLD_CYC, STAGE_GAP);
    localparam int IW = idx_w(NUM_DOM);
    // The timer is compared before it increments, so terms are one short.
    localparam logic [TW-1:0] HOLD_TERM = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] GAP_TERM  = TW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DOM - 1);

    seq_state_e         state_r;
    logic [IW-1:0]      idx_r;
    logic               armed_r;
    logic               ack_r;
    logic               seq_done_r;
    logic [NUM_DOM-1:0] dom_r;
    logic [CNT_W-1:0]   rst_cnt_r;

    logic               tmr_clr_s;
    logic [TW-1:0]      tmr_term_s;
    logic [TW-1:0]      tmr_count_s;
    logic               tmr_tc_s;
    logic [IW-1:0]      idx_nxt_s;
    logic               idx_last_s;

    assign idx_nxt_s  = idx_r + IW'(1);
    assign idx_last_s = (idx_r == LAST_IDX);

    // Select the phase length and hold the timer at zero while running.
    always_comb begin
        tmr_clr_s  = 1'b0;
        tmr_term_s = HOLD_TERM;
        if (state_r == ST_HOLD) begin
            tmr_term_s = HOLD_TERM;
        end else begin
            tmr_term_s = GAP_TERM;
        end
        if (state_r == ST_RUN) begin
            tmr_clr_s = 1'b1;
        end else if (tmr_tc_s) begin
            tmr_clr_s = 1'b1;
        end else begin
            tmr_clr_s = 1'b0;
        end
    end

    qcs_rst_seq_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_s),
        .term  (tmr_term_s),
        .count (tmr_count_s),
        .tc    (tmr_tc_s)
    );

    // Sequencer FSM with registered outputs and handshake bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_HOLD;
            idx_r      <= {IW{1'b0}};
            armed_r    <= 1'b1;
            ack_r      <= 1'b0;
            seq_done_r <= 1'b0;
            dom_r      <= {NUM_DOM{1'b0}};
            rst_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            ack_r <= 1'b0;
            if (!sw_rst_req) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                ST_HOLD: begin
                    if (tmr_tc_s) begin
                        dom_r[0] <= 1'b1;
                        state_r  <= (NUM_DOM == 1) ? ST_RUN : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (idx_last_s) begin
                        state_r    <= ST_RUN;
                        seq_done_r <= 1'b1;
                    end else if (tmr_tc_s) begin
                        idx_r            <= idx_nxt_s;
                        dom_r[idx_nxt_s] <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (sw_rst_req && armed_r) begin
                        dom_r      <= {NUM_DOM{1'b0}};
                        seq_done_r <= 1'b0;
                        ack_r      <= 1'b1;
                        armed_r    <= 1'b0;
                        state_r    <= ST_HOLD;
                        idx_r      <= {IW{1'b0}};
                        if (rst_cnt_r != {CNT_W{1'b1}}) begin
                            rst_cnt_r <= rst_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        seq_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_HOLD;
                    idx_r      <= {IW{1'b0}};
                    seq_done_r <= 1'b0;
                    dom_r      <= {NUM_DOM{1'b0}};
                end
            endcase
        end
    end

    assign sw_rst_ack = ack_r;
    assign dom_rst_n  = dom_r;
    assign seq_done   = seq_done_r;
    assign rst_cnt    = rst_cnt_r;

endmodule
